// File: rtl/uart_tx_fifo_reader.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo_reader
//
// Drains the read side of a TX FIFO and serialises each word onto an
// asynchronous serial line: start bit, DATA_WIDTH data bits LSB first,
// optional parity bit, then STOP_BITS stop bits. The bit period comes from
// an internal clock counter (CLKS_PER_BIT clk cycles per bit).
//
// Frames run back-to-back with no idle gap while the FIFO is non-empty.
// The next word is loaded on the last cycle of the current stop bit.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   tx_enable   1 = new frames may start; a running frame always completes
//   fifo_empty  FIFO empty flag
//   fifo_data   FIFO head word, valid whenever fifo_empty = 0
//   fifo_rd_en  one-cycle pop strobe, asserted in the load cycle
//   tx          serial line (registered), idles high
//   busy        1 while a frame is in progress (registered with tx)
//   tx_done     one-cycle pulse on the final cycle of the last stop bit
// ---------------------------------------------------------------------------
module uart_tx_fifo_reader #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tx_enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic          PAR_INV   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                  state_reg,    state_next;
    logic [CW-1:0]           cnt_reg,      cnt_next;
    logic [BW-1:0]           bit_idx_reg,  bit_idx_next;
    logic                    stop_idx_reg, stop_idx_next;
    logic [DATA_WIDTH-1:0]   shift_reg,    shift_next;
    logic                    parity_reg,   parity_next;
    logic                    tx_reg,       tx_next;
    logic                    busy_reg,     busy_next;

    logic                    bit_end;
    logic                    load_ok;
    logic                    rd_en_int;
    logic                    done_int;
    logic [DATA_WIDTH-1:0]   shifted;

    assign bit_end = (cnt_reg == CNT_LAST);
    assign load_ok = tx_enable && !fifo_empty;
    assign shifted = shift_reg >> 1;

    // -----------------------------------------------------------------------
    // State register. tx and busy are registered so the line is glitch-free;
    // the combinational block therefore computes the value each output must
    // take during the *next* cycle.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            cnt_reg      <= '0;
            bit_idx_reg  <= '0;
            stop_idx_reg <= 1'b0;
            shift_reg    <= '0;
            parity_reg   <= 1'b0;
            tx_reg       <= 1'b1;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            bit_idx_reg  <= bit_idx_next;
            stop_idx_reg <= stop_idx_next;
            shift_reg    <= shift_next;
            parity_reg   <= parity_next;
            tx_reg       <= tx_next;
            busy_reg     <= busy_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic.
    // -----------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        cnt_next      = bit_end ? '0 : cnt_reg + CW'(1);
        bit_idx_next  = bit_idx_reg;
        stop_idx_next = stop_idx_reg;
        shift_next    = shift_reg;
        parity_next   = parity_reg;
        tx_next       = tx_reg;
        busy_next     = busy_reg;
        rd_en_int     = 1'b0;
        done_int      = 1'b0;

        case (state_reg)
            S_IDLE: begin
                cnt_next  = '0;
                tx_next   = 1'b1;
                busy_next = 1'b0;
                if (load_ok) begin
                    shift_next  = fifo_data;
                    // Parity is taken from the word as loaded, before any
                    // shifting, so it is ready when the PARITY bit starts.
                    parity_next = (^fifo_data) ^ PAR_INV;
                    rd_en_int   = 1'b1;
                    state_next  = S_START;
                    tx_next     = 1'b0;
                    busy_next   = 1'b1;
                end
            end

            S_START: begin
                if (bit_end) begin
                    state_next   = S_DATA;
                    bit_idx_next = '0;
                    tx_next      = shift_reg[0];
                end
            end

            S_DATA: begin
                if (bit_end) begin
                    if (bit_idx_reg == BIT_LAST) begin
                        stop_idx_next = 1'b0;
                        if (PARITY_EN != 0) begin
                            state_next = S_PARITY;
                            tx_next    = parity_reg;
                        end else begin
                            state_next = S_STOP;
                            tx_next    = 1'b1;
                        end
                    end else begin
                        bit_idx_next = bit_idx_reg + BW'(1);
                        shift_next   = shifted;
                        tx_next      = shifted[0];
                    end
                end
            end

            S_PARITY: begin
                if (bit_end) begin
                    state_next    = S_STOP;
                    stop_idx_next = 1'b0;
                    tx_next       = 1'b1;
                end
            end

            S_STOP: begin
                tx_next = 1'b1;
                if (bit_end) begin
                    if (stop_idx_reg == STOP_LAST) begin
                        done_int = 1'b1;
                        // Last stop cycle doubles as a load cycle so that
                        // queued words go out with no idle gap.
                        if (load_ok) begin
                            shift_next  = fifo_data;
                            parity_next = (^fifo_data) ^ PAR_INV;
                            rd_en_int   = 1'b1;
                            state_next  = S_START;
                            tx_next     = 1'b0;
                            busy_next   = 1'b1;
                        end else begin
                            state_next = S_IDLE;
                            busy_next  = 1'b0;
                        end
                    end else begin
                        stop_idx_next = 1'b1;
                    end
                end
            end

            default: begin
                state_next = S_IDLE;
                tx_next    = 1'b1;
                busy_next  = 1'b0;
            end
        endcase
    end

    // The state is IDLE while reset is held, so the combinational load
    // condition would otherwise pop a non-empty FIFO during reset.
    assign fifo_rd_en = rd_en_int && !rst;
    assign tx_done    = done_int && !rst;
    assign tx         = tx_reg;
    assign busy       = busy_reg;

endmodule

// File: doc/uart_tx_fifo_reader.md
Name: uart_tx_fifo_reader

Overview:
UART transmitter that drains the TX FIFO (the read side of the fifo_mem storage) and serialises each byte onto the tx line as an asynchronous frame: start bit, DATA_WIDTH data bits LSB first, optional parity, then 1 or 2 stop bits.
- An internal baud divider sets the bit period; no external baud tick.
- Pops one FIFO entry per frame. Frames run back-to-back with no idle gap while the FIFO is non-empty.

Parameters:
DATA_WIDTH, 8, data bits per frame; matches FIFO word width.
CLKS_PER_BIT, 868, clk cycles per bit (100 MHz / 115200); must be >= 2.
PARITY_EN, 0, 1 = append parity bit after data.
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored if PARITY_EN = 0.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  asynchronous, active-high reset.
tx_enable  input  1  1 = may start new frames; a frame in progress always completes.
fifo_empty  input  1  FIFO empty flag.
fifo_data  input  DATA_WIDTH  FIFO head word; combinational read, valid whenever fifo_empty = 0.
fifo_rd_en  output  1  one-cycle pop strobe to the FIFO read pointer.
tx  output  1  serial line; idles high.
busy  output  1  1 while a frame is in progress.
tx_done  output  1  one-cycle pulse on the final cycle of each frame's last stop bit.

Behaviour:
- Reset (async, immediate): tx = 1, busy = 0, fifo_rd_en = 0, tx_done = 0, state = IDLE, counters and shift register cleared.
- Reset mid-frame: the line returns high at once and the popped byte is discarded. No pop or resend occurs after release.
- States: IDLE, START, DATA, PARITY, STOP.
- Bit timing: a clk counter of width clog2(CLKS_PER_BIT) counts 0..CLKS_PER_BIT-1.
  - Each START, DATA and PARITY bit lasts exactly CLKS_PER_BIT cycles.
  - STOP lasts STOP_BITS*CLKS_PER_BIT cycles.
- IDLE: tx = 1, busy = 0.
  - Load condition: tx_enable = 1 and fifo_empty = 0 in the same cycle.
  - On the load condition: fifo_data is latched into the shift register, fifo_rd_en = 1 for that cycle only, and the next state is START.
- START: tx = 0 from the cycle after the load cycle. tx is a registered output, so load-to-start-edge latency is 1 clk.
- DATA: the shift register's LSB drives tx, shifting right once per bit. A bit index 0..DATA_WIDTH-1 moves to PARITY (if PARITY_EN) or STOP after the last bit.
- PARITY: tx = XOR of the latched data bits, inverted if PARITY_ODD = 1.
- STOP: tx = 1. On the final stop cycle, tx_done = 1 for that cycle, then:
  - if tx_enable = 1 and fifo_empty = 0: load the next word and pulse fifo_rd_en in that same cycle, then go to START. busy stays 1 and tx carries no extra idle bit.
  - otherwise go to IDLE.
- busy = 1 in every state except IDLE; it is registered alongside tx.
- Frame length: (1 + DATA_WIDTH + PARITY_EN + STOP_BITS) * CLKS_PER_BIT cycles.
- Changes to fifo_empty, fifo_data or tx_enable are ignored outside the load cycle (IDLE, or the final STOP cycle). Dropping tx_enable mid-frame only prevents the next load.
- Empty-FIFO protection: fifo_rd_en is never asserted while fifo_empty = 1, so the FIFO is never popped when empty.
- At most one fifo_rd_en pulse per frame.

Test Plan:
(All scenarios use CLKS_PER_BIT = 4.)
1. Reset: hold rst = 1 with fifo_empty = 0 -> tx = 1, busy = 0, fifo_rd_en = 0, tx_done = 0. Assert rst asynchronously between clk edges -> outputs change without waiting for an edge.
2. Single byte, PARITY_EN = 0, STOP_BITS = 1: fifo_data = 0xA5, fifo_empty 1 -> 0 for one pop.
   - Exactly one fifo_rd_en pulse.
   - tx bits 0,1,0,1,0,0,1,0,1,1, each 4 cycles (40-cycle frame).
   - tx_done on cycle 40 after the pop; busy falls the next cycle.
3. Back-to-back: FIFO holds 0x00 then 0xFF.
   - Second fifo_rd_en on the last stop cycle of frame 1.
   - busy continuously 1 for 80 cycles; tx has no high cycle between stop 1 and start 2.
   - Two tx_done pulses, 40 cycles apart.
4. Parity: byte 0x07.
   - PARITY_EN = 1, PARITY_ODD = 0 -> parity bit 1; with PARITY_ODD = 1 -> parity bit 0.
   - Frame 44 cycles. STOP_BITS = 2 -> stop high 8 cycles, frame 48 cycles.
5. Reset mid-frame: assert rst during data bit 3 of 0x3C.
   - tx = 1 and busy = 0 immediately.
   - After release with fifo_empty = 1, no fifo_rd_en and tx stays 1.
6. tx_enable gating:
   - tx_enable = 0 with fifo_empty = 0 -> no fifo_rd_en for 100 cycles.
   - Raise tx_enable, then drop it during data bit 2 -> current frame completes, no second pop, state returns to IDLE.
